master: RTL and testbench

MASTER -- requirements
Module: master

---
 rtl/master.sv | 124 ++++++++++++
 tb/tb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/master.sv
// AHB-Lite bus master: two-stage address/data pipeline driven by a
// simple application request port, with INCR/WRAP burst addressing.
module master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [1:0]  ATRANS,
  input  logic        Burst,
  input  logic [31:0] AADDR,
  input  logic        AWRITE,
  input  logic [31:0] AWDATA,
  input  logic [2:0]  ASIZE,
  input  logic [2:0]  ABURST,
  output logic        hold,
  output logic [31:0] ARDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTLOCK
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [1:0] A_IDLE   = 2'd0;
  localparam logic [1:0] A_NONSEQ = 2'd1;
  localparam logic [1:0] A_SEQ    = 2'd2;
  localparam logic [1:0] A_BUSY   = 2'd3;

  logic [31:0] wdata_q;
  logic        d_active;
  logic        d_write;

  logic [1:0]  trans_nxt;
  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] seq_addr;
  logic [31:0] addr_nxt;
  logic        wrap;

  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign hold      = ~HRESETn & ~HREADY;

  always_comb begin
    trans_nxt = T_IDLE;
    if (start) begin
      unique case (ATRANS)
        A_IDLE:   trans_nxt = T_IDLE;
        A_NONSEQ: trans_nxt = T_NONSEQ;
        A_SEQ:    trans_nxt = T_SEQ;
        A_BUSY:   trans_nxt = T_BUSY;
        default:  trans_nxt = T_IDLE;
      endcase
    end
  end

  // Wrap block is beats * transfer size bytes, naturally aligned.
  always_comb begin
    incr      = 32'd1 << HSIZE;
    wrap      = 1'b1;
    wrap_mask = 32'd0;
    unique case (ABURST)
      3'd2:    wrap_mask = (32'd4 << HSIZE) - 32'd1;
      3'd4:    wrap_mask = (32'd8 << HSIZE) - 32'd1;
      3'd6:    wrap_mask = (32'd16 << HSIZE) - 32'd1;
      default: wrap      = 1'b0;
    endcase
    if (wrap)
      seq_addr = (HADDR & ~wrap_mask) | ((HADDR + incr) & wrap_mask);
    else
      seq_addr = HADDR + incr;
  end

  // BUSY inside a burst parks the address until the next SEQ.
  always_comb begin
    addr_nxt = AADDR;
    if (start && Burst && ATRANS == A_SEQ)
      addr_nxt = seq_addr;
    else if (start && Burst && ATRANS == A_BUSY)
      addr_nxt = HADDR;
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      HADDR    <= 32'd0;
      HTRANS   <= T_IDLE;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'd0;
      HBURST   <= 3'd0;
      wdata_q  <= 32'd0;
      d_active <= 1'b0;
      d_write  <= 1'b0;
      HWDATA   <= 32'd0;
      ARDATA   <= 32'd0;
    end else if (HRESP && !HREADY) begin
      HTRANS   <= T_IDLE;
      d_active <= 1'b0;
    end else if (HREADY) begin
      if (d_active && !d_write)
        ARDATA <= HRDATA;
      HADDR    <= addr_nxt;
      HTRANS   <= trans_nxt;
      HWRITE   <= AWRITE;
      HSIZE    <= ASIZE;
      HBURST   <= ABURST;
      wdata_q  <= AWDATA;
      d_active <= (HTRANS == T_NONSEQ) || (HTRANS == T_SEQ);
      d_write  <= HWRITE;
      if (((HTRANS == T_NONSEQ) || (HTRANS == T_SEQ)) && HWRITE)
        HWDATA <= wdata_q;
    end
  end

endmodule

// File: tb/tb_master.sv
// Directed bench for the AHB master: reset, single transfers, waits,
// INCR/WRAP bursts, BUSY, error cancel and reset mid-burst.
module tb_master;

  logic        HCLK_tb;
  logic        HRESETn;
  logic        start;
  logic [1:0]  ATRANS;
  logic        Burst;
  logic [31:0] AADDR;
  logic        AWRITE;
  logic [31:0] AWDATA;
  logic [2:0]  ASIZE;
  logic [2:0]  ABURST;
  logic        hold;
  logic [31:0] ARDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;

  int n_chk;
  int n_fail;

  master dut (
    .HCLK(HCLK_tb), .HRESETn(HRESETn),
    .start(start), .ATRANS(ATRANS), .Burst(Burst),
    .AADDR(AADDR), .AWRITE(AWRITE), .AWDATA(AWDATA),
    .ASIZE(ASIZE), .ABURST(ABURST),
    .hold(hold), .ARDATA(ARDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK)
  );

  initial HCLK_tb = 1'b0;
  always #5 HCLK_tb = ~HCLK_tb;

  task automatic tick();
    @(posedge HCLK_tb);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] t, input logic b,
                     input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [2:0] sz,
                     input logic [2:0] bu);
    start  = 1'b1;
    ATRANS = t;
    Burst  = b;
    AADDR  = a;
    AWRITE = w;
    AWDATA = wd;
    ASIZE  = sz;
    ABURST = bu;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_haddr"},  HADDR, 32'd0);
    chk({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_ardata"}, ARDATA, 32'd0);
    chk({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
    chk({tag, "_hsize"},  {29'd0, HSIZE}, 32'd0);
    chk({tag, "_hburst"}, {29'd0, HBURST}, 32'd0);
    chk({tag, "_hold"},   {31'd0, hold}, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    HRESETn = 1'b1;
    start = 1'b0; ATRANS = 2'd0; Burst = 1'b0;
    AADDR = 32'd0; AWRITE = 1'b0; AWDATA = 32'd0;
    ASIZE = 3'd0; ABURST = 3'd0;
    HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'h1234;
    tick();
    tick();
    chk_reset("rst");
    chk("hprot", {28'd0, HPROT}, 32'h3);
    chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);

    HRESETn = 1'b0;
    HREADY  = 1'b1;
    tick();

    // single read
    req(2'd1, 1'b0, 32'hA, 1'b0, 32'd0, 3'd2, 3'd0);
    tick();
    chk("rd_haddr", HADDR, 32'hA);
    chk("rd_htrans", {30'd0, HTRANS}, 32'h2);
    chk("rd_hwrite", {31'd0, HWRITE}, 32'd0);
    start = 1'b0; HRDATA = 32'd5;
    tick();
    chk("rd_idle", {30'd0, HTRANS}, 32'h0);
    tick();
    chk("rd_ardata", ARDATA, 32'd5);

    // single write
    req(2'd1, 1'b0, 32'hA, 1'b1, 32'd8, 3'd2, 3'd0);
    tick();
    chk("wr_haddr", HADDR, 32'hA);
    chk("wr_hwrite", {31'd0, HWRITE}, 32'd1);
    start = 1'b0; HRDATA = 32'h77;
    tick();
    chk("wr_hwdata", HWDATA, 32'd8);
    chk("wr_idle", {30'd0, HTRANS}, 32'h0);
    tick();
    chk("wr_no_rdload", ARDATA, 32'd5);

    // wait states
    req(2'd1, 1'b0, 32'hA, 1'b0, 32'd0, 3'd2, 3'd0);
    tick();
    req(2'd1, 1'b0, 32'hB, 1'b0, 32'd0, 3'd2, 3'd0);
    tick();
    HREADY = 1'b0;
    req(2'd2, 1'b0, 32'hFF, 1'b1, 32'd0, 3'd0, 3'd0);
    #1;
    chk("ws_hold0", {31'd0, hold}, 32'd1);
    tick();
    chk("ws_haddr1", HADDR, 32'hB);
    chk("ws_htrans1", {30'd0, HTRANS}, 32'h2);
    chk("ws_hold1", {31'd0, hold}, 32'd1);
    tick();
    chk("ws_haddr2", HADDR, 32'hB);
    chk("ws_hwrite2", {31'd0, HWRITE}, 32'd0);
    chk("ws_ardata_held", ARDATA, 32'd5);
    HREADY = 1'b1; HRDATA = 32'h55; start = 1'b0;
    #1;
    chk("ws_hold_off", {31'd0, hold}, 32'd0);
    tick();
    chk("ws_ardata_a", ARDATA, 32'h55);
    HRDATA = 32'h66;
    tick();
    chk("ws_ardata_b", ARDATA, 32'h66);

    // INCR word read burst with a stall
    req(2'd1, 1'b0, 32'h20, 1'b0, 32'd0, 3'd2, 3'd1);
    tick();
    chk("incr_a0", HADDR, 32'h20);
    chk("incr_t0", {30'd0, HTRANS}, 32'h2);
    req(2'd2, 1'b1, 32'h0, 1'b0, 32'd0, 3'd2, 3'd1);
    tick();
    chk("incr_a1", HADDR, 32'h24);
    chk("incr_t1", {30'd0, HTRANS}, 32'h3);
    tick();
    chk("incr_a2", HADDR, 32'h28);
    HREADY = 1'b0;
    tick();
    chk("incr_stall", HADDR, 32'h28);
    HREADY = 1'b1;
    tick();
    chk("incr_a3", HADDR, 32'h2C);
    start = 1'b0;
    tick();
    tick();

    // mixed halfword write burst then word read burst
    req(2'd1, 1'b0, 32'h20, 1'b1, 32'h20, 3'd1, 3'd1);
    tick();
    chk("mix_a0", HADDR, 32'h20);
    req(2'd2, 1'b1, 32'h0, 1'b1, 32'h22, 3'd1, 3'd1);
    tick();
    chk("mix_a1", HADDR, 32'h22);
    chk("mix_wd0", HWDATA, 32'h20);
    req(2'd1, 1'b0, 32'h5C, 1'b0, 32'd0, 3'd2, 3'd1);
    tick();
    chk("mix_a2", HADDR, 32'h5C);
    chk("mix_wd1", HWDATA, 32'h22);
    req(2'd2, 1'b1, 32'h0, 1'b0, 32'd0, 3'd2, 3'd1);
    tick();
    chk("mix_a3", HADDR, 32'h60);
    chk("mix_t3", {30'd0, HTRANS}, 32'h3);
    start = 1'b0; HRDATA = 32'h5C;
    tick();
    chk("mix_rd0", ARDATA, 32'h5C);
    HRDATA = 32'h60;
    tick();
    chk("mix_rd1", ARDATA, 32'h60);
    chk("mix_wd_keep", HWDATA, 32'h22);

    // WRAP4 word burst, then BUSY
    req(2'd1, 1'b0, 32'h38, 1'b0, 32'd0, 3'd2, 3'd2);
    tick();
    chk("wrap_a0", HADDR, 32'h38);
    req(2'd2, 1'b1, 32'h0, 1'b0, 32'd0, 3'd2, 3'd2);
    tick();
    chk("wrap_a1", HADDR, 32'h3C);
    tick();
    chk("wrap_a2", HADDR, 32'h30);
    tick();
    chk("wrap_a3", HADDR, 32'h34);
    req(2'd3, 1'b1, 32'h0, 1'b0, 32'd0, 3'd2, 3'd2);
    tick();
    chk("busy_t", {30'd0, HTRANS}, 32'h1);
    chk("busy_a", HADDR, 32'h34);
    start = 1'b0; HRDATA = 32'hAB;
    tick();
    chk("busy_rd", ARDATA, 32'hAB);
    HRDATA = 32'hCD;
    tick();
    chk("busy_noload", ARDATA, 32'hAB);

    // error response cancels the pending write
    req(2'd1, 1'b0, 32'h100, 1'b1, 32'h99, 3'd2, 3'd0);
    tick();
    chk("err_a", HADDR, 32'h100);
    chk("err_t", {30'd0, HTRANS}, 32'h2);
    start = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("err_idle", {30'd0, HTRANS}, 32'h0);
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    chk("err_cancel", HWDATA, 32'h22);
    tick();
    chk("err_cancel2", HWDATA, 32'h22);

    // reset in the middle of a write burst
    req(2'd1, 1'b0, 32'h40, 1'b1, 32'h11, 3'd2, 3'd1);
    tick();
    req(2'd2, 1'b1, 32'h0, 1'b1, 32'h12, 3'd2, 3'd1);
    tick();
    chk("rb_wd", HWDATA, 32'h11);
    chk("rb_a", HADDR, 32'h44);
    HRESETn = 1'b1; HREADY = 1'b0;
    tick();
    chk_reset("rb");
    HRESETn = 1'b0; HREADY = 1'b1; start = 1'b0;
    tick();
    tick();
    chk("rb_after_wd", HWDATA, 32'd0);
    chk("rb_after_t", {30'd0, HTRANS}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
